// File: rtl/stream_decoder_fifo.sv
// stream_decoder_fifo
//
// Accepts a stream of binary indices and decodes each one into a one-hot or
// thermometer word of OUT_W bits. Indices that do not fit in OUT_W produce an
// all-zero word flagged with err, and bump a saturating error counter. Decoded
// results sit in a 2-entry in-order FIFO so a stalled consumer loses nothing.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds data stable while valid is
// high and ready is low; ready never depends combinationally on the partner's
// valid (in_ready depends only on stored occupancy and rst).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input index valid
//   in_ready   block can accept an index this cycle
//   in_data    binary index (IN_W bits)
//   in_mode    0 = one-hot, 1 = thermometer; sampled with in_data
//   out_valid  head entry present on out_data/out_err
//   out_ready  consumer accepts the head entry
//   out_data   decoded word of the head entry (0 when empty)
//   out_err    head entry came from an out-of-range index (0 when empty)
//   err_count  saturating count of accepted out-of-range indices
//   clr_err    synchronous clear of err_count

module stream_decoder_fifo #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_err
);

    // Entry 0 is always the head; entry 1 is only meaningful at occupancy 2.
    logic [1:0]       occ_q, occ_d;
    logic [OUT_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push, pop;
    logic [OUT_W-1:0] dec_data;
    logic             dec_err;

    assign in_ready  = !rst && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage may hold stale words after a pop; gate so an empty FIFO shows 0.
    assign out_data  = out_valid ? data0_q : '0;
    assign out_err   = out_valid && err0_q;
    assign err_count = cnt_q;

    // Decode of the incoming index; only ever consumed by a register.
    always_comb begin
        int idx;
        idx      = int'(in_data);
        dec_data = '0;
        dec_err  = 1'b0;
        if (idx >= OUT_W) begin
            dec_err = 1'b1;
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                dec_data[i] = in_mode ? (i <= idx) : (i == idx);
            end
        end
    end

    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    data0_d = dec_data;
                    err0_d  = dec_err;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    // Head leaves, the new entry takes its place.
                    data0_d = dec_data;
                    err0_d  = dec_err;
                end else if (push) begin
                    data1_d = dec_data;
                    err1_d  = dec_err;
                    occ_d   = 2'd2;
                end else if (pop) begin
                    occ_d   = 2'd0;
                end
            end
            default: begin
                // Full: in_ready is low, so only a pop can happen.
                if (pop) begin
                    data0_d = data1_q;
                    err0_d  = err1_q;
                    occ_d   = 2'd1;
                end
            end
        endcase
    end

    // A clear coinciding with an accepted error leaves a count of one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_err) begin
            cnt_d = (push && dec_err) ? CNT_W'(1) : '0;
        end else if (push && dec_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_decoder_fifo.sv
// Bench for stream_decoder_fifo. Two instances share all inputs: dut_a uses
// the default parameters, dut_b uses OUT_W=6, CNT_W=2 to reach the
// out-of-range and saturation cases. Handshake timing depends only on
// occupancy, so both instances stay in lockstep.
module tb_stream_decoder_fifo;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic [2:0] in_data   = 3'd0;
    logic       in_mode   = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_err   = 1'b0;

    logic       in_ready_a, out_valid_a, out_err_a;
    logic [7:0] out_data_a, err_count_a;
    logic       in_ready_b, out_valid_b, out_err_b;
    logic [5:0] out_data_b;
    logic [1:0] err_count_b;

    stream_decoder_fifo #(.IN_W(3), .OUT_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_err(out_err_a),
        .err_count(err_count_a), .clr_err(clr_err)
    );

    stream_decoder_fifo #(.IN_W(3), .OUT_W(6), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_err(out_err_b),
        .err_count(err_count_b), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Entries are {err, data[7:0]}; dut_b data is zero-extended from 6 bits.
    logic [8:0] exp_qa[$];
    logic [8:0] exp_qb[$];
    logic [8:0] log_a[$];
    logic [8:0] log_b[$];
    logic [8:0] want[$];
    int         ecnt_a = 0;
    int         ecnt_b = 0;
    logic [8:0] snap_a = 9'h0;
    logic [8:0] snap_b = 9'h0;
    bit         m_push, m_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the rules: 1<<idx, or (2^(idx+1))-1, or error.
    function automatic logic [8:0] ref_dec(input int idx, input int mode, input int ow);
        int val;
        if (idx >= ow) return 9'h100;
        val = (mode != 0) ? ((1 << (idx + 1)) - 1) : (1 << idx);
        return {1'b0, val[7:0]};
    endfunction

    function automatic int next_cnt(input int c, input bit clr, input bit e, input int maxv);
        if (clr) return e ? 1 : 0;
        if (e && c < maxv) return c + 1;
        return c;
    endfunction

    // Reference model: queue-level FIFO behaviour at each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_push = in_valid && (exp_qa.size() < 2);
            m_pop  = (exp_qa.size() > 0) && out_ready;
            if (m_pop) begin
                log_a.push_back(snap_a);
                log_b.push_back(snap_b);
                void'(exp_qa.pop_front());
                void'(exp_qb.pop_front());
            end
            if (m_push) begin
                exp_qa.push_back(ref_dec(int'(in_data), int'(in_mode), 8));
                exp_qb.push_back(ref_dec(int'(in_data), int'(in_mode), 6));
            end
            ecnt_a = next_cnt(ecnt_a, clr_err, m_push && (int'(in_data) >= 8), 255);
            ecnt_b = next_cnt(ecnt_b, clr_err, m_push && (int'(in_data) >= 6), 3);
        end
    end

    always @(posedge rst) begin
        exp_qa.delete();
        exp_qb.delete();
        ecnt_a = 0;
        ecnt_b = 0;
    end

    // Compare process: every falling edge, all outputs of both instances.
    always @(negedge clk) begin
        logic [8:0] ha, hb;
        ha = (exp_qa.size() > 0) ? exp_qa[0] : 9'h0;
        hb = (exp_qb.size() > 0) ? exp_qb[0] : 9'h0;
        check("a_in_ready",  in_ready_a,  !rst && (exp_qa.size() < 2));
        check("a_out_valid", out_valid_a, exp_qa.size() > 0);
        check("a_out_data",  out_data_a,  ha[7:0]);
        check("a_out_err",   out_err_a,   ha[8]);
        check("a_err_count", err_count_a, ecnt_a);
        check("b_in_ready",  in_ready_b,  !rst && (exp_qb.size() < 2));
        check("b_out_valid", out_valid_b, exp_qb.size() > 0);
        check("b_out_data",  out_data_b,  hb[5:0]);
        check("b_out_err",   out_err_b,   hb[8]);
        check("b_err_count", err_count_b, ecnt_b);
        snap_a = {out_err_a, out_data_a};
        snap_b = {out_err_b, 2'b00, out_data_b};
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    // Offer one index until accepted; tries = number of edges it took.
    task automatic send(input int idx, input int mode, output int tries);
        logic got;
        tries    = 0;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = idx[2:0];
        in_mode  = mode[0];
        while (!got && tries < 40) begin
            #3;
            got = in_ready_a;
            tries++;
            cycle();
        end
        in_valid = 1'b0;
        if (!got) check("send_timeout", got, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_b.delete();
    endtask

    task automatic check_log(input string nm, input bit use_b);
        int n;
        n = use_b ? log_b.size() : log_a.size();
        check({nm, "_count"}, n, want.size());
        for (int i = 0; i < want.size() && i < n; i++)
            check(nm, use_b ? log_b[i] : log_a[i], want[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] w;

        // Reset state
        repeat (2) cycle();
        check("rst_in_ready",  in_ready_a,  0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data",  out_data_a,  0);
        check("rst_err_count", err_count_b, 0);
        rst = 1'b0;
        #1;
        check("release_in_ready", in_ready_a, 1);

        // 1: one-hot sweep, no stalls
        out_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            send(i, 0, t);
            check("t1_nostall", t, 1);
        end
        drain();
        want.delete();
        for (int i = 0; i < 8; i++) begin
            w = 32'd1 << i;
            want.push_back(w[8:0]);
        end
        check_log("t1_onehot", 1'b0);

        // 2: thermometer
        clear_logs();
        send(0, 1, t);
        send(3, 1, t);
        send(7, 1, t);
        drain();
        want = '{9'h001, 9'h00F, 9'h0FF};
        check_log("t2_thermo", 1'b0);

        // 3: OUT_W=6 range edge in thermometer mode
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        clear_logs();
        send(5, 1, t);
        send(6, 1, t);
        send(7, 1, t);
        drain();
        want = '{9'h03F, 9'h100, 9'h100};
        check_log("t3_range", 1'b1);
        check("t3_err_count", err_count_b, 2);

        // 5: saturation and clear-with-error
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        for (int i = 0; i < 5; i++) send(7, 0, t);
        drain();
        check("t5_saturate", err_count_b, 3);
        clr_err = 1'b1;
        send(6, 0, t);
        clr_err = 1'b0;
        check("t5_clr_plus_err", err_count_b, 1);
        drain();

        // 4: backpressure
        clear_logs();
        out_ready = 1'b0;
        send(2, 0, t);
        send(4, 0, t);
        in_valid = 1'b1;
        in_data  = 3'd6;
        in_mode  = 1'b0;
        cycle();
        cycle();
        check("t4_full_ready", in_ready_a, 0);
        check("t4_hold_data",  out_data_a, 8'h04);
        out_ready = 1'b1;
        send(6, 0, t);
        check("t4_accept_after_pop", t, 2);
        drain();
        want = '{9'h004, 9'h010, 9'h040};
        check_log("t4_order", 1'b0);
        clear_logs();
        for (int i = 1; i < 7; i++) begin
            send(i, 0, t);
            check("t4_throughput", t, 1);
        end
        drain();
        check("t4_throughput_count", log_a.size(), 6);

        // 6: async reset with a full FIFO
        out_ready = 1'b0;
        send(3, 0, t);
        send(5, 0, t);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_out_valid_a", out_valid_a, 0);
        check("t6_out_valid_b", out_valid_b, 0);
        check("t6_out_data",    out_data_a,  0);
        check("t6_err_count",   err_count_b, 0);
        check("t6_in_ready",    in_ready_a,  0);
        cycle();
        rst = 1'b0;
        #1;
        check("t6_ready_release", in_ready_a, 1);
        clear_logs();
        out_ready = 1'b1;
        send(1, 0, t);
        drain();
        want = '{9'h002};
        check_log("t6_after_reset", 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 3'($urandom_range(0, 7));
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            clr_err   = ($urandom_range(0, 31) == 0);
            cycle();
        end
        clr_err = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
